// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants and types for the simple CPU
package cpu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_file_write_decoder.sv
// rtl/reg_file_write_decoder.sv - one-hot write-enable demux for the register file
module write_decoder #(
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]      addr,
    input  logic                       write,
    output logic [2**ADDR_WIDTH-1:0]   load_en
);

    // Exactly one load enable goes high per write; none when write is low.
    always_comb begin
        load_en = '0;
        if (write) begin
            load_en[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x8 register file, one write port, two combinational read ports
module reg_file #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2
);

    localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] load_en;

    write_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_write_decoder (
        .addr    (INADDRESS),
        .write   (WRITE),
        .load_en (load_en)
    );

    // Register array: async clear, otherwise load the one decoded entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (load_en[i]) begin
                    regs[i] <= IN;
                end
            end
        end
    end

    // Read port 1: stored value, forwarded write data when bypassing, zero in reset.
    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        if (!RESET_N) begin
            OUT1 = '0;
        end else if (BYPASS && WRITE && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end
    end

    // Read port 2: same selection as port 1, forwarded independently.
    always_comb begin
        OUT2 = regs[OUT2ADDRESS];
        if (!RESET_N) begin
            OUT2 = '0;
        end else if (BYPASS && WRITE && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file, both bypass modes
module tb_reg_file;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] din;
    logic [2:0] waddr;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] o1_b, o2_b, o1_n, o2_n;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [8];

    reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b1)) u_byp (
        .CLK(clk), .RESET_N(rst_n), .IN(din), .INADDRESS(waddr), .WRITE(wr),
        .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1_b), .OUT2(o2_b)
    );

    reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1'b0)) u_nobyp (
        .CLK(clk), .RESET_N(rst_n), .IN(din), .INADDRESS(waddr), .WRITE(wr),
        .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1_n), .OUT2(o2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_out(input logic [2:0] a, input bit byp);
        if (!rst_n) return 8'h00;
        if (byp && wr && (a == waddr)) return din;
        return mdl[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    endtask

    task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] d,
                         input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clk);
        wr = w; waddr = wa; din = d; a1 = r1; a2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && wr) mdl[waddr] = din;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; wr = 1'b0; din = 8'h00; waddr = 3'd0; a1 = 3'd0; a2 = 3'd0;
        #2 rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i);
            #1;
            checks += 2;
            if (o1_b !== 8'h00) begin errors++; $display("FAIL reset_o1_byp: addr %0d got %h expected 00", i, o1_b); end
            if (o2_n !== 8'h00) begin errors++; $display("FAIL reset_o2_nobyp: addr %0d got %h expected 00", 7 - i, o2_n); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 8'h5A, 3'd3, 3'd3);
        tick();
        checks++;
        if (o1_n !== 8'h5A) begin errors++; $display("FAIL reset_preload_r3: got %h expected 5a", o1_n); end
        @(negedge clk);
        wr = 1'b0;
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        checks += 2;
        if (o1_b !== 8'h00) begin errors++; $display("FAIL reset_async_byp: got %h expected 00", o1_b); end
        if (o1_n !== 8'h00) begin errors++; $display("FAIL reset_async_nobyp: got %h expected 00", o1_n); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(i);
            #1;
            checks++;
            if (o1_n !== 8'h00) begin errors++; $display("FAIL reset_cleared: R%0d got %h expected 00", i, o1_n); end
        end
    endtask

    task automatic test_sweep();
        logic [2:0] p1 [3];
        logic [2:0] p2 [3];
        logic [7:0] e1 [3];
        logic [7:0] e2 [3];
        p1 = '{3'd0, 3'd3, 3'd5}; p2 = '{3'd7, 3'd4, 3'd5};
        e1 = '{8'h10, 8'h13, 8'h15}; e2 = '{8'h17, 8'h14, 8'h15};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 8'(8'h10 + i), 3'(i), 3'd0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 3'd0, 8'h00, p1[k], p2[k]);
            #1;
            checks += 4;
            if (o1_b !== e1[k]) begin errors++; $display("FAIL sweep_o1_byp: pair %0d got %h expected %h", k, o1_b, e1[k]); end
            if (o2_b !== e2[k]) begin errors++; $display("FAIL sweep_o2_byp: pair %0d got %h expected %h", k, o2_b, e2[k]); end
            if (o1_n !== e1[k]) begin errors++; $display("FAIL sweep_o1_nobyp: pair %0d got %h expected %h", k, o1_n, e1[k]); end
            if (o2_n !== e2[k]) begin errors++; $display("FAIL sweep_o2_nobyp: pair %0d got %h expected %h", k, o2_n, e2[k]); end
        end
    endtask

    task automatic test_write_low();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 3'd2, 8'hFF, 3'd2, 3'd2);
            tick();
            checks += 2;
            if (o1_b !== 8'h12) begin errors++; $display("FAIL write_low_byp: cycle %0d got %h expected 12", c, o1_b); end
            if (o2_n !== 8'h12) begin errors++; $display("FAIL write_low_nobyp: cycle %0d got %h expected 12", c, o2_n); end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 3'd4, 8'hAB, 3'd4, 3'd0);
        #1;
        checks += 3;
        if (o1_b !== 8'hAB) begin errors++; $display("FAIL bypass_pre_byp: got %h expected ab", o1_b); end
        if (o1_n !== 8'h14) begin errors++; $display("FAIL bypass_pre_nobyp: got %h expected 14", o1_n); end
        if (o2_b !== 8'h10) begin errors++; $display("FAIL bypass_other_port: got %h expected 10", o2_b); end
        tick();
        checks += 2;
        if (o1_b !== 8'hAB) begin errors++; $display("FAIL bypass_post_byp: got %h expected ab", o1_b); end
        if (o1_n !== 8'hAB) begin errors++; $display("FAIL bypass_post_nobyp: got %h expected ab", o1_n); end
    endtask

    task automatic test_collision();
        drive(1'b1, 3'd6, 8'h77, 3'd6, 3'd6);
        rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if (o1_b !== 8'h00) begin errors++; $display("FAIL collision_bypass_off: got %h expected 00", o1_b); end
        tick();
        @(negedge clk);
        rst_n = 1'b1; wr = 1'b0;
        #1;
        checks += 2;
        if (o1_b !== 8'h00) begin errors++; $display("FAIL collision_r6_byp: got %h expected 00", o1_b); end
        if (o2_n !== 8'h00) begin errors++; $display("FAIL collision_r6_nobyp: got %h expected 00", o2_n); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 3'd1, 8'(k), 3'd1, 3'd1);
            tick();
            checks += 2;
            if (o1_n !== 8'(k)) begin errors++; $display("FAIL b2b_nobyp: step %0d got %h expected %h", k, o1_n, 8'(k)); end
            if (o2_b !== 8'(k)) begin errors++; $display("FAIL b2b_byp: step %0d got %h expected %h", k, o2_b, 8'(k)); end
        end
        drive(1'b0, 3'd1, 8'hEE, 3'd1, 3'd1);
        tick();
        checks++;
        if (o1_n !== 8'h03) begin errors++; $display("FAIL b2b_hold: got %h expected 03", o1_n); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 31) != 0);
            if (!rst_n) clear_model();
            wr    = 1'($urandom_range(0, 1));
            waddr = 3'($urandom_range(0, 7));
            din   = 8'($urandom);
            a1    = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
            a2    = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
            #1;
            checks += 4;
            if (o1_b !== exp_out(a1, 1'b1)) begin errors++; $display("FAIL rand_pre_o1_byp: it %0d got %h expected %h", n, o1_b, exp_out(a1, 1'b1)); end
            if (o2_b !== exp_out(a2, 1'b1)) begin errors++; $display("FAIL rand_pre_o2_byp: it %0d got %h expected %h", n, o2_b, exp_out(a2, 1'b1)); end
            if (o1_n !== exp_out(a1, 1'b0)) begin errors++; $display("FAIL rand_pre_o1_nobyp: it %0d got %h expected %h", n, o1_n, exp_out(a1, 1'b0)); end
            if (o2_n !== exp_out(a2, 1'b0)) begin errors++; $display("FAIL rand_pre_o2_nobyp: it %0d got %h expected %h", n, o2_n, exp_out(a2, 1'b0)); end
            tick();
            checks += 2;
            if (o1_n !== exp_out(a1, 1'b0)) begin errors++; $display("FAIL rand_post_o1_nobyp: it %0d got %h expected %h", n, o1_n, exp_out(a1, 1'b0)); end
            if (o2_b !== exp_out(a2, 1'b1)) begin errors++; $display("FAIL rand_post_o2_byp: it %0d got %h expected %h", n, o2_b, exp_out(a2, 1'b1)); end
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_sweep();
        test_write_low();
        test_bypass();
        test_collision();
        test_sweep();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
